// File: rtl/maze_pkg.sv
// Shared definitions for the maze environment model.
//  - cell-code constants and barrier helpers
//  - orientation, command and FSM state enums
//  - maze_init_cell: the built-in map image (row-major, 3-bit cell codes)
package maze_pkg;

  localparam logic [2:0] CELL_WALL  = 3'd0;
  localparam logic [2:0] CELL_PATH  = 3'd1;
  localparam logic [2:0] CELL_B3    = 3'd2;
  localparam logic [2:0] CELL_B6    = 3'd3;
  localparam logic [2:0] CELL_B9    = 3'd4;
  localparam logic [2:0] CELL_BLACK = 3'd7;

  // Incrementing the heading turns left: N->W->S->E->N.
  typedef enum logic [1:0] {OR_N = 2'd0, OR_W = 2'd1, OR_S = 2'd2, OR_E = 2'd3} orient_e;
  typedef enum logic [1:0] {OP_FWD = 2'd0, OP_TURN_L = 2'd1, OP_TURN_R = 2'd2, OP_REMOVE = 2'd3} cmd_op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REMOVING = 2'd1, ST_DONE = 2'd2} state_e;

  function automatic logic is_barrier(input logic [2:0] c);
    return (c == CELL_B3) || (c == CELL_B6) || (c == CELL_B9);
  endfunction

  function automatic logic [2:0] lower_barrier(input logic [2:0] c);
    case (c)
      CELL_B9: return CELL_B6;
      CELL_B6: return CELL_B3;
      default: return CELL_PATH;
    endcase
  endfunction

  // Built-in map: column 0 is an open corridor (with the PATH-alias codes
  // 5 and 6 mixed in), a B9 barrier next to the start, a WALL one row up
  // from it, and the BLACK goal at the top of column 1.
  function automatic logic [2:0] maze_init_cell(input int rows, input int r, input int c);
    if (r == rows - 1 && c == 1) return CELL_B9;
    if (r == rows - 2 && c == 1) return CELL_WALL;
    if (r == 0 && c == 1)        return CELL_BLACK;
    if (c == 0 && r == rows / 2) return 3'd5;
    if (c == 0 && r == 1)        return 3'd6;
    return CELL_PATH;
  endfunction

endpackage

// File: rtl/maze_neighbor.sv
// Neighbour-coordinate generator.
//  i_row/i_col/i_orient : current position and heading
//  o_ahead_*            : cell one step ahead, o_ahead_ok=0 when off the map
//  o_left_*             : cell one step to the left of the heading
// Off-map neighbours return the current coordinates so downstream map
// indexing always stays inside the array.
module maze_neighbor import maze_pkg::*; #(
  parameter int ROWS  = 10,
  parameter int COLS  = 20,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  input  logic [1:0]       i_orient,
  output logic [ROW_W-1:0] o_ahead_row,
  output logic [COL_W-1:0] o_ahead_col,
  output logic             o_ahead_ok,
  output logic [ROW_W-1:0] o_left_row,
  output logic [COL_W-1:0] o_left_col,
  output logic             o_left_ok
);

  localparam int NB_W = 1 + ROW_W + COL_W;

  function automatic logic [NB_W-1:0] step(input logic [ROW_W-1:0] r_in,
                                           input logic [COL_W-1:0] c_in,
                                           input logic [1:0]       dir);
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    logic             ok;
    r  = r_in;
    c  = c_in;
    ok = 1'b0;
    case (orient_e'(dir))
      OR_N: if (r_in != '0) begin
        r = r_in - ROW_W'(1); ok = 1'b1;
      end
      OR_S: if (r_in != ROW_W'(ROWS - 1)) begin
        r = r_in + ROW_W'(1); ok = 1'b1;
      end
      OR_W: if (c_in != '0) begin
        c = c_in - COL_W'(1); ok = 1'b1;
      end
      default: if (c_in != COL_W'(COLS - 1)) begin
        c = c_in + COL_W'(1); ok = 1'b1;
      end
    endcase
    return {ok, r, c};
  endfunction

  always_comb begin
    {o_ahead_ok, o_ahead_row, o_ahead_col} = step(i_row, i_col, i_orient);
    {o_left_ok,  o_left_row,  o_left_col } = step(i_row, i_col, i_orient + 2'd1);
  end

endmodule

// File: rtl/maze_world_ctrl.sv
// Maze environment model: ROWS x COLS cell map, robot position/heading,
// sensor answers and a one-command-per-handshake executor.
//  clock/reset          : rising-edge clock, async active-low reset
//  cmd_valid/op/ready   : command handshake (FWD, TURN_L, TURN_R, REMOVE)
//  head/left/under/barrier_out : combinational sensors
//  bump_out/remove_done : registered 1-cycle pulses
//  goal_out             : sticky, robot reached BLACK
//  row/col/orient_out, step_count : robot state
// Build option MAZE_MAP_RESTORE_EN: reset reloads the whole map from the
// constant image, so removed barriers come back. Without it the map is only
// initialised once and barrier removal survives reset.
// The map image comes from maze_pkg::maze_init_cell (row-major, 3-bit codes).
module maze_world_ctrl import maze_pkg::*; #(
  parameter int ROWS       = 10,
  parameter int COLS       = 20,
  parameter int START_ROW  = ROWS - 1,
  parameter int START_COL  = 0,
  parameter int HIT_CYCLES = 3,
  parameter int ROW_W      = $clog2(ROWS),
  parameter int COL_W      = $clog2(COLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             head_out,
  output logic             left_out,
  output logic             under_out,
  output logic             barrier_out,
  output logic             bump_out,
  output logic             remove_done,
  output logic             goal_out,
  output logic [ROW_W-1:0] row_out,
  output logic [COL_W-1:0] col_out,
  output logic [1:0]       orient_out,
  output logic [15:0]      step_count
);

  localparam int MAP_W = 3 * ROWS * COLS;
  localparam int IDX_W = $clog2(MAP_W);
  localparam int CNT_W = $clog2(HIT_CYCLES + 1);

  function automatic logic [MAP_W-1:0] build_map();
    logic [MAP_W-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[(r * COLS + c) * 3 +: 3] = maze_init_cell(ROWS, r, c);
    return m;
  endfunction

  localparam logic [MAP_W-1:0] LP_MAP_INIT = build_map();

  state_e            r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_orient;
  logic [15:0]       r_step;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bump, r_remove_done, r_goal;

  logic [ROW_W-1:0]  w_ahead_row, w_left_row;
  logic [COL_W-1:0]  w_ahead_col, w_left_col;
  logic              w_ahead_ok, w_left_ok;
  logic [IDX_W-1:0]  w_cur_base, w_ahead_base, w_left_base;
  logic [2:0]        w_cell_cur, w_cell_ahead, w_cell_left;
  logic              w_can_move, w_barrier_ahead;
  logic              w_mv, w_tl, w_tr, w_bump_nxt, w_rm_start, w_rm_apply;

  maze_neighbor #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_nb (
    .i_row       (r_row),
    .i_col       (r_col),
    .i_orient    (r_orient),
    .o_ahead_row (w_ahead_row),
    .o_ahead_col (w_ahead_col),
    .o_ahead_ok  (w_ahead_ok),
    .o_left_row  (w_left_row),
    .o_left_col  (w_left_col),
    .o_left_ok   (w_left_ok)
  );

  // ---------------- map storage ----------------
`ifdef MAZE_MAP_RESTORE_EN
  logic [MAP_W-1:0] r_map;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_map <= LP_MAP_INIT;
    else if (w_rm_apply) r_map[w_ahead_base +: 3] <= lower_barrier(w_cell_ahead);
  end
`else
  // Power-up image only; deliberately not touched by reset.
  logic [MAP_W-1:0] r_map = LP_MAP_INIT;

  always_ff @(posedge clock) begin
    if (w_rm_apply) r_map[w_ahead_base +: 3] <= lower_barrier(w_cell_ahead);
  end
`endif

  assign w_cur_base   = IDX_W'((int'(r_row)       * COLS + int'(r_col))       * 3);
  assign w_ahead_base = IDX_W'((int'(w_ahead_row) * COLS + int'(w_ahead_col)) * 3);
  assign w_left_base  = IDX_W'((int'(w_left_row)  * COLS + int'(w_left_col))  * 3);

  assign w_cell_cur   = r_map[w_cur_base   +: 3];
  assign w_cell_ahead = r_map[w_ahead_base +: 3];
  assign w_cell_left  = r_map[w_left_base  +: 3];

  assign w_barrier_ahead = w_ahead_ok && is_barrier(w_cell_ahead);
  assign w_can_move      = w_ahead_ok && (w_cell_ahead != CELL_WALL) && !is_barrier(w_cell_ahead);

  // ---------------- sensors ----------------
  assign head_out    = !w_ahead_ok || (w_cell_ahead == CELL_WALL);
  assign left_out    = !w_left_ok  || (w_cell_left  == CELL_WALL);
  assign under_out   = (w_cell_cur == CELL_BLACK);
  assign barrier_out = w_barrier_ahead;

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    w_mv        = 1'b0;
    w_tl        = 1'b0;
    w_tr        = 1'b0;
    w_bump_nxt  = 1'b0;
    w_rm_start  = 1'b0;
    w_rm_apply  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OP_FWD: begin
              if (w_can_move) begin
                w_mv = 1'b1;
                if (w_cell_ahead == CELL_BLACK) w_state_nxt = ST_DONE;
              end else begin
                w_bump_nxt = 1'b1;
              end
            end
            OP_TURN_L: w_tl = 1'b1;
            OP_TURN_R: w_tr = 1'b1;
            default: begin
              if (w_barrier_ahead) begin
                w_rm_start  = 1'b1;
                w_state_nxt = ST_REMOVING;
              end else begin
                w_bump_nxt = 1'b1;
              end
            end
          endcase
        end
      end
      ST_REMOVING: begin
        if (r_cnt == CNT_W'(HIT_CYCLES - 1)) begin
          w_rm_apply  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- robot state ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row         <= ROW_W'(START_ROW);
      r_col         <= COL_W'(START_COL);
      r_orient      <= OR_N;
      r_step        <= '0;
      r_cnt         <= '0;
      r_bump        <= 1'b0;
      r_remove_done <= 1'b0;
      r_goal        <= 1'b0;
    end else begin
      r_bump        <= w_bump_nxt;
      r_remove_done <= w_rm_apply;
      if (w_mv) begin
        r_row <= w_ahead_row;
        r_col <= w_ahead_col;
        if (r_step != 16'hFFFF) r_step <= r_step + 16'd1;
      end
      if (w_state_nxt == ST_DONE) r_goal <= 1'b1;
      if (w_tl) r_orient <= r_orient + 2'd1;
      if (w_tr) r_orient <= r_orient - 2'd1;
      if (w_rm_start)                r_cnt <= '0;
      else if (r_state == ST_REMOVING) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bump_out    = r_bump;
  assign remove_done = r_remove_done;
  assign goal_out    = r_goal;
  assign row_out     = r_row;
  assign col_out     = r_col;
  assign orient_out  = r_orient;
  assign step_count  = r_step;

endmodule

// File: tb/tb_maze_world_ctrl.sv
// Directed bench for maze_world_ctrl with default parameters and the
// built-in map: start (9,0) N, (9,1)=B9, (8,1)=WALL, (0,1)=BLACK,
// column 0 open (codes 1/5/6).
module tb_maze_world_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready, head_out, left_out, under_out, barrier_out;
  logic        bump_out, remove_done, goal_out;
  logic [3:0]  row_out;
  logic [4:0]  col_out;
  logic [1:0]  orient_out;
  logic [15:0] step_count;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [1:0] FWD = 2'd0, TL = 2'd1, TR = 2'd2, RM = 2'd3;

  maze_world_ctrl dut (
    .clock(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .head_out(head_out), .left_out(left_out),
    .under_out(under_out), .barrier_out(barrier_out), .bump_out(bump_out),
    .remove_done(remove_done), .goal_out(goal_out), .row_out(row_out),
    .col_out(col_out), .orient_out(orient_out), .step_count(step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Offer one command for one edge; returns 1 time unit after that edge.
  task automatic send(input logic [1:0] op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({row_out, col_out} !== {4'd9, 5'd0}) $display("FAIL rst_pos got %0d,%0d want 9,0", row_out, col_out); else pass_cnt++;
    total++; if (orient_out !== 2'd0) $display("FAIL rst_orient got %0d want 0", orient_out); else pass_cnt++;
    total++; if (step_count !== 16'd0) $display("FAIL rst_steps got %0d want 0", step_count); else pass_cnt++;
    total++; if ({bump_out, remove_done, goal_out} !== 3'b000) $display("FAIL rst_pulses got %b want 000", {bump_out, remove_done, goal_out}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", cmd_ready); else pass_cnt++;
    // Ahead (8,0) PATH, left is off the west edge.
    total++; if ({head_out, left_out, barrier_out, under_out} !== 4'b0100)
      $display("FAIL rst_sensors got %b want 0100", {head_out, left_out, barrier_out, under_out}); else pass_cnt++;
  endtask

  task automatic test_turns();
    send(TR);
    total++; if (orient_out !== 2'd3) $display("FAIL turn_r got %0d want 3", orient_out); else pass_cnt++;
    // Facing E: ahead (9,1)=B9, left (8,0)=PATH.
    total++; if ({head_out, left_out, barrier_out} !== 3'b001)
      $display("FAIL turn_r_sensors got %b want 001", {head_out, left_out, barrier_out}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      send(TL);
      total++; if (orient_out !== 2'(i)) $display("FAIL turn_l_%0d got %0d want %0d", i, orient_out, i); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_remove();
    send(RM);
    total++; if (cmd_ready !== 1'b0) $display("FAIL abort_busy got %b want 0", cmd_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({cmd_ready, remove_done, orient_out} !== 4'b1000)
      $display("FAIL abort_idle got %b want 1000", {cmd_ready, remove_done, orient_out}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    send(TR);
    total++; if (barrier_out !== 1'b1) $display("FAIL abort_cell got %b want 1", barrier_out); else pass_cnt++;
  endtask

  // Facing E at (9,0) with an intact B9 ahead: three removes clear it.
  task automatic test_remove();
    int n;
    for (int k = 0; k < 3; k++) begin
      send(RM);
      n = 0;
      while (!cmd_ready && n < 20) begin
        n++;
        @(posedge clk);
        #1;
      end
      total++; if (n !== 3) $display("FAIL rm%0d_busy got %0d want 3", k, n); else pass_cnt++;
      total++; if (remove_done !== 1'b1) $display("FAIL rm%0d_done got %b want 1", k, remove_done); else pass_cnt++;
      total++; if (barrier_out !== (k < 2)) $display("FAIL rm%0d_barrier got %b want %b", k, barrier_out, k < 2); else pass_cnt++;
      @(posedge clk);
      #1;
      total++; if (remove_done !== 1'b0) $display("FAIL rm%0d_done_clr got %b want 0", k, remove_done); else pass_cnt++;
    end
    send(RM);
    total++; if ({bump_out, cmd_ready} !== 2'b11) $display("FAIL rm_nobarrier got %b want 11", {bump_out, cmd_ready}); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (bump_out !== 1'b0) $display("FAIL rm_bump_clr got %b want 0", bump_out); else pass_cnt++;
  endtask

  task automatic test_restore();
    pulse_reset();
    send(TR);
`ifdef MAZE_MAP_RESTORE_EN
    total++; if (barrier_out !== 1'b1) $display("FAIL restore got %b want 1", barrier_out); else pass_cnt++;
`else
    total++; if (barrier_out !== 1'b0) $display("FAIL persist got %b want 0", barrier_out); else pass_cnt++;
`endif
    send(TL);
  endtask

  task automatic test_wall();
    send(FWD);
    total++; if ({row_out, step_count, bump_out} !== {4'd8, 16'd1, 1'b0})
      $display("FAIL fwd1 got row %0d steps %0d bump %b want 8 1 0", row_out, step_count, bump_out); else pass_cnt++;
    send(TR);
    total++; if ({head_out, barrier_out} !== 2'b10) $display("FAIL wall_sense got %b want 10", {head_out, barrier_out}); else pass_cnt++;
    send(FWD);
    total++; if ({bump_out, col_out, step_count} !== {1'b1, 5'd0, 16'd1})
      $display("FAIL wall_bump got bump %b col %0d steps %0d want 1 0 1", bump_out, col_out, step_count); else pass_cnt++;
    send(TL);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = TR;
    @(posedge clk);
    #1;
    total++; if (orient_out !== 2'd3) $display("FAIL b2b_first got %0d want 3", orient_out); else pass_cnt++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    total++; if (orient_out !== 2'd2) $display("FAIL b2b_second got %0d want 2", orient_out); else pass_cnt++;
    send(TL);
    send(TL);
  endtask

  task automatic test_top_edge();
    repeat (8) send(FWD);
    total++; if ({row_out, step_count, head_out} !== {4'd0, 16'd9, 1'b1})
      $display("FAIL top_reach got row %0d steps %0d head %b want 0 9 1", row_out, step_count, head_out); else pass_cnt++;
    send(FWD);
    total++; if ({bump_out, row_out, step_count} !== {1'b1, 4'd0, 16'd9})
      $display("FAIL top_bump got bump %b row %0d steps %0d want 1 0 9", bump_out, row_out, step_count); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (bump_out !== 1'b0) $display("FAIL top_bump_clr got %b want 0", bump_out); else pass_cnt++;
  endtask

  task automatic test_goal();
    send(TR);
    total++; if ({head_out, under_out} !== 2'b00) $display("FAIL goal_pre got %b want 00", {head_out, under_out}); else pass_cnt++;
    send(FWD);
    total++; if ({col_out, under_out, goal_out, cmd_ready} !== {5'd1, 3'b110})
      $display("FAIL goal_hit got col %0d u/g/r %b want 1 110", col_out, {under_out, goal_out, cmd_ready}); else pass_cnt++;
    total++; if (step_count !== 16'd10) $display("FAIL goal_steps got %0d want 10", step_count); else pass_cnt++;
    send(TL);
    send(FWD);
    total++; if ({orient_out, col_out, step_count, goal_out} !== {2'd3, 5'd1, 16'd10, 1'b1})
      $display("FAIL goal_hold got orient %0d col %0d steps %0d goal %b", orient_out, col_out, step_count, goal_out); else pass_cnt++;
    pulse_reset();
    total++; if ({goal_out, cmd_ready, row_out, col_out} !== {2'b01, 4'd9, 5'd0})
      $display("FAIL goal_reset got goal %b ready %b pos %0d,%0d", goal_out, cmd_ready, row_out, col_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_turns();
    test_reset_mid_remove();
    test_remove();
    test_restore();
    test_wall();
    test_back_to_back();
    test_top_edge();
    test_goal();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
